// File: rtl/fxp_calc.sv
// fxp_calc: registered precision-reduction unit.
//
// Converts one fixed-point or integer word from the input format
// (I_PREC bits, I_FRAC fraction bits) to a narrower output format
// (O_PREC bits, O_FRAC fraction bits). The result is saturated to the
// output range and three event flags are produced with each result.
// The conversion is combinational and only the output stage is registered,
// so a result appears one cycle after its input is presented.
//
// Parameters:
//   DTYPE  "FXP" or "INT"; with "INT" both fraction widths are treated as 0
//   SIGN   1 = two's-complement signed, 0 = unsigned (input and output)
//   I_PREC input word width, I_FRAC input fraction bits
//   O_PREC output word width (O_PREC <= I_PREC), O_FRAC output fraction bits
//
// Ports:
//   clk        clock
//   reset_     asynchronous active-low reset
//   in_valid   input word valid
//   in         input word, I_PREC bits
//   out_valid  result valid, one cycle after in_valid
//   out        converted result, O_PREC bits
//   ovf        result saturated to max or min
//   udf        nonzero input truncated to zero
//   rounded    nonzero bits were discarded by the fraction alignment
//
// Optional feature macro: ROUND_NEAREST_EN
//   Defined:   round half up (add 2^(D-1) before the right shift).
//   Undefined: pure truncation toward minus infinity.

module fxp_calc #(
  parameter string DTYPE  = "FXP",
  parameter bit    SIGN   = 1'b1,
  parameter int    I_PREC = 16,
  parameter int    I_FRAC = 4,
  parameter int    O_PREC = 8,
  parameter int    O_FRAC = 3
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              in_valid,
  input  logic [I_PREC-1:0] in,
  output logic              out_valid,
  output logic [O_PREC-1:0] out,
  output logic              ovf,
  output logic              udf,
  output logic              rounded
);

  localparam int W_IF = (DTYPE == "INT") ? 0 : I_FRAC;
  localparam int W_OF = (DTYPE == "INT") ? 0 : O_FRAC;
  localparam int D    = W_IF - W_OF;
  localparam int AD   = (D < 0) ? -D : D;
  // One guard bit above the widest shifted value keeps the working value
  // non-negative in unsigned mode, so one signed compare serves both modes.
  localparam int AW   = I_PREC + AD + 1;

  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW-1:0] MAXV = SIGN ? ((ONE << (O_PREC - 1)) - ONE)
                                        : ((ONE << O_PREC) - ONE);
  localparam logic [AW-1:0] MINV = SIGN ? ~((ONE << (O_PREC - 1)) - ONE)
                                        : '0;

  logic              w_sbit;
  logic [AW-1:0]     w_ext;
  logic [AW-1:0]     w_aligned;
  logic              w_lost;
  logic              w_hi;
  logic              w_lo;
  logic [O_PREC-1:0] w_res;
  logic              w_ovf;
  logic              w_udf;

  // Extend to the working width: sign-extend in signed mode, zero-extend otherwise.
  assign w_sbit = SIGN & in[I_PREC-1];
  assign w_ext  = {{(AW - I_PREC){w_sbit}}, in};

  generate
    if (D > 0) begin : g_shr
      logic [AW-1:0] w_src;
      logic          w_fill;
`ifdef ROUND_NEAREST_EN
      // Half-LSB bias; the guard bits absorb any carry, which the range
      // check then saturates.
      assign w_src = w_ext + (ONE << (D - 1));
`else
      assign w_src = w_ext;
`endif
      // Arithmetic shift built from a logical shift plus a fill mask, which
      // avoids signedness surprises in mixed-sign expressions.
      assign w_fill    = SIGN & w_src[AW-1];
      assign w_aligned = (w_src >> D) | (w_fill ? ~({AW{1'b1}} >> D) : '0);
      // Discarded bits are judged on the original source, not the biased one.
      assign w_lost    = |w_ext[D-1:0];
    end else if (D < 0) begin : g_shl
      assign w_aligned = w_ext << AD;
      assign w_lost    = 1'b0;
    end else begin : g_none
      assign w_aligned = w_ext;
      assign w_lost    = 1'b0;
    end
  endgenerate

  // Range check and saturation on the full-width aligned value.
  always_comb begin
    w_hi  = $signed(w_aligned) > $signed(MAXV);
    w_lo  = $signed(w_aligned) < $signed(MINV);
    w_res = w_aligned[O_PREC-1:0];
    if (w_hi) begin
      w_res = MAXV[O_PREC-1:0];
    end else if (w_lo) begin
      w_res = MINV[O_PREC-1:0];
    end
    w_ovf = w_hi | w_lo;
    w_udf = (in != '0) && (w_aligned == '0);
  end

  // Output stage: capture on valid words, hold the result otherwise.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      out_valid <= 1'b0;
      out       <= '0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      rounded   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out     <= w_res;
        ovf     <= w_ovf;
        udf     <= w_udf;
        rounded <= w_lost;
      end
    end
  end

endmodule

// File: tb/tb_fxp_calc.sv
// tb_fxp_calc: self-checking bench for fxp_calc.
// The main instance uses the default format (FXP, signed, Q12.4 -> Q5.3,
// rounding feature off); a second instance covers INT 16 -> 8 bit.

module tb_fxp_calc;

  logic       clk;
  logic       reset_;
  logic       in_valid;
  logic [15:0] in;
  logic       out_valid;
  logic [7:0] out;
  logic       ovf;
  logic       udf;
  logic       rounded;

  logic       iInValid;
  logic [15:0] iIn;
  logic       iOutValid;
  logic [7:0] iOut;
  logic       iOvf;
  logic       iUdf;
  logic       iRounded;

  int tests;
  int failures;

  typedef struct {
    string       name;
    logic [15:0] din;
    logic [7:0]  eOut;
    logic        eOvf;
    logic        eUdf;
    logic        eRnd;
  } vec_t;

  vec_t vecs[$];

  fxp_calc dut (
    .clk       (clk),
    .reset_    (reset_),
    .in_valid  (in_valid),
    .in        (in),
    .out_valid (out_valid),
    .out       (out),
    .ovf       (ovf),
    .udf       (udf),
    .rounded   (rounded)
  );

  fxp_calc #(
    .DTYPE  ("INT"),
    .SIGN   (1'b1),
    .I_PREC (16),
    .I_FRAC (4),
    .O_PREC (8),
    .O_FRAC (3)
  ) dutInt (
    .clk       (clk),
    .reset_    (reset_),
    .in_valid  (iInValid),
    .in        (iIn),
    .out_valid (iOutValid),
    .out       (iOut),
    .ovf       (iOvf),
    .udf       (iUdf),
    .rounded   (iRounded)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: floor(x / 2) by exact division, clamp to [-128, 127].
  function automatic logic [10:0] refConv(input logic [15:0] din);
    int   x;
    int   a;
    logic o;
    logic u;
    logic r;
    logic [7:0] res;
    x = int'($signed(din));
    r = din[0];
    a = (x - (x & 1)) / 2;
    o = 1'b0;
    if (a > 127) begin
      res = 8'h7F;
      o   = 1'b1;
    end else if (a < -128) begin
      res = 8'h80;
      o   = 1'b1;
    end else begin
      res = a[7:0];
    end
    u = (x != 0) && (a == 0);
    return {res, o, u, r};
  endfunction

  task automatic applyStimulus(input logic v, input logic [15:0] din);
    @(negedge clk);
    in_valid = v;
    in       = din;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name,
                             input logic aV, input logic [7:0] aOut,
                             input logic aOvf, input logic aUdf, input logic aRnd,
                             input logic eV, input logic [7:0] eOut,
                             input logic eOvf, input logic eUdf, input logic eRnd);
    tests++;
    if ({aV, aOut, aOvf, aUdf, aRnd} !== {eV, eOut, eOvf, eUdf, eRnd}) begin
      failures++;
      $display("[TB] FAIL %s: got v=%b out=%h ovf=%b udf=%b rnd=%b, expected v=%b out=%h ovf=%b udf=%b rnd=%b",
               name, aV, aOut, aOvf, aUdf, aRnd, eV, eOut, eOvf, eUdf, eRnd);
    end
  endtask

  initial begin
    logic [10:0] exp;
    logic [7:0]  hOut;
    logic        hOvf;
    logic        hUdf;
    logic        hRnd;
    logic        v;
    logic [15:0] d;

    tests    = 0;
    failures = 0;

    vecs.push_back('{"pos_1p75",   16'h001C, 8'h0E, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"pos_7p5",    16'h0078, 8'h3C, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"neg_16",     16'hFF00, 8'h80, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"sat_max",    16'h0100, 8'h7F, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{"sat_min",    16'hFEC0, 8'h80, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{"lost_lsb",   16'h0011, 8'h08, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{"underflow",  16'h0001, 8'h00, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{"neg_lsb",    16'hFFFF, 8'hFF, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{"max_exact",  16'h00FE, 8'h7F, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"max_plus",   16'h00FF, 8'h7F, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{"zero",       16'h0000, 8'h00, 1'b0, 1'b0, 1'b0});

    reset_   = 1'b0;
    in_valid = 1'b0;
    in       = 16'h0000;
    iInValid = 1'b0;
    iIn      = 16'h0000;
    #12;
    checkOutput("reset_state", out_valid, out, ovf, udf, rounded,
                1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_ = 1'b1;

    // Directed table
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(1'b1, vecs[i].din);
      checkOutput(vecs[i].name, out_valid, out, ovf, udf, rounded,
                  1'b1, vecs[i].eOut, vecs[i].eOvf, vecs[i].eUdf, vecs[i].eRnd);
    end

    // Idle cycle holds the last result but drops out_valid
    applyStimulus(1'b1, 16'h0001);
    applyStimulus(1'b0, 16'h0100);
    checkOutput("idle_hold", out_valid, out, ovf, udf, rounded,
                1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

    // Back-to-back words, then reset mid-stream between clock edges
    applyStimulus(1'b1, 16'h001C);
    checkOutput("b2b_0", out_valid, out, ovf, udf, rounded, 1'b1, 8'h0E, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0100);
    checkOutput("b2b_1", out_valid, out, ovf, udf, rounded, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hFFFF);
    checkOutput("b2b_2", out_valid, out, ovf, udf, rounded, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    in       = 16'h0078;
    #2;
    reset_ = 1'b0;
    #1;
    checkOutput("mid_reset", out_valid, out, ovf, udf, rounded,
                1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("reset_held", out_valid, out, ovf, udf, rounded,
                1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    reset_   = 1'b1;

    // Random words against the reference model
    hOut = 8'h00;
    hOvf = 1'b0;
    hUdf = 1'b0;
    hRnd = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      v = ($urandom_range(3) != 0);
      case ($urandom_range(3))
        0:       d = 16'($urandom_range(15)) - 16'd8;
        1:       d = 16'($urandom_range(600)) - 16'd300;
        default: d = 16'($urandom);
      endcase
      applyStimulus(v, d);
      if (v) begin
        exp  = refConv(d);
        hOut = exp[10:3];
        hOvf = exp[2];
        hUdf = exp[1];
        hRnd = exp[0];
      end
      checkOutput("random", out_valid, out, ovf, udf, rounded,
                  v, hOut, hOvf, hUdf, hRnd);
    end
    applyStimulus(1'b0, 16'h0000);

    // INT 16 -> 8 bit instance
    @(negedge clk);
    iInValid = 1'b1;
    iIn      = 16'd2;
    @(posedge clk);
    #1;
    checkOutput("int_2", iOutValid, iOut, iOvf, iUdf, iRounded, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    iIn = 16'd10;
    @(posedge clk);
    #1;
    checkOutput("int_10", iOutValid, iOut, iOvf, iUdf, iRounded, 1'b1, 8'd10, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    iIn = 16'd300;
    @(posedge clk);
    #1;
    checkOutput("int_300", iOutValid, iOut, iOvf, iUdf, iRounded, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    iIn = 16'hFF00;
    @(posedge clk);
    #1;
    checkOutput("int_neg256", iOutValid, iOut, iOvf, iUdf, iRounded, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    iInValid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
